// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes raw switch pins, debounces each bit and flags accepted edges
module switch_debouncer #(
    parameter int WIDTH       = 8,
    parameter int CNT_MAX     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] swt_raw,
    output logic [WIDTH-1:0] swt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CW-1:0]    r_cnt  [WIDTH];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_done;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign w_diff  = w_sync ^ swt;
    assign changed = |(rise | fall);

    // a bit is accepted when it still differs on the edge its count reaches the last value
    always_comb begin
        w_done = '0;
        for (int i = 0; i < WIDTH; i++)
            w_done[i] = w_diff[i] && (r_cnt[i] == LAST);
    end

    // plain flop chain bringing the raw pins into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                r_sync[s] <= '0;
        end else begin
            r_sync[0] <= swt_raw;
            for (int s = 1; s < SYNC_STAGES; s++)
                r_sync[s] <= r_sync[s-1];
        end
    end

    // stability counters: restart on agreement or on acceptance, otherwise count up
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++)
                r_cnt[i] <= (!w_diff[i] || w_done[i]) ? '0 : r_cnt[i] + 1'b1;
        end
    end

    // accepted levels plus single-cycle edge pulses aligned with the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            swt  <= '0;
            rise <= '0;
            fall <= '0;
        end else begin
            swt  <= swt ^ w_done;
            rise <= w_done & w_sync;
            fall <= w_done & ~w_sync;
        end
    end
endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the board's slide switches.
- Synchronizes the 8 raw asynchronous switch inputs into the clock domain and debounces each bit independently.
- Emits a clean switch vector, which feeds the switch-to-LED logic's swt input directly, plus one-cycle rise/fall pulses for later labs that need edge events.

Parameters:
- WIDTH, 8, number of switch bits.
- CNT_MAX, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz). Must be ≥1; the bench uses 4.
- SYNC_STAGES, 2, synchronizer flop depth. Must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- swt_raw  input  WIDTH  raw switch pins, asynchronous to clk.
- swt  output  WIDTH  debounced, registered switch levels.
- rise  output  WIDTH  one-cycle pulse per bit when swt[i] goes 0→1.
- fall  output  WIDTH  one-cycle pulse per bit when swt[i] goes 1→0.
- changed  output  1  OR of all rise and fall bits, same cycle.

Behaviour:
- Reset
  - When rst=1 at a rising edge, clear all synchronizer flops, counters, swt, rise and fall to 0; changed=0.
  - Reset overrides all other activity. Any in-progress count is discarded.
- Synchronizer
  - Each bit passes through a SYNC_STAGES flop chain. sync[i] is the last stage.
  - No logic sits between the stages.
- Per-bit debounce
  - Each bit has an independent counter of width clog2(CNT_MAX), minimum 1 bit.
  - If sync[i]==swt[i], the counter clears to 0.
  - If sync[i]!=swt[i] and counter<CNT_MAX-1, the counter increments.
  - If sync[i]!=swt[i] and counter==CNT_MAX-1, then on that edge: swt[i]<=sync[i], counter<=0, and rise[i] or fall[i]<=1 according to the new level.
- Latency
  - A raw level that is held steady appears on swt[i] at the (SYNC_STAGES+CNT_MAX)th rising edge after the change. The first edge sampling the new raw value counts as edge 1.
  - Example: with CNT_MAX=4 and SYNC_STAGES=2, the change appears at edge 6.
- Glitch rejection
  - Any return of sync[i] to swt[i] before the count completes clears the counter. swt[i] does not change and no pulse is emitted.
  - A raw pulse of fewer than CNT_MAX cycles (after synchronization) is always rejected.
- Pulses
  - rise/fall are registered and asserted exactly one cycle, coincident with the first cycle swt[i] shows the new level.
  - They deassert on the next edge unless another accepted transition occurs there. This is impossible for the same bit, because at least CNT_MAX cycles separate accepted changes.
  - rise[i] and fall[i] are never both 1.
- Multi-bit behaviour
  - Bits are fully independent. Simultaneous changes on several bits may pulse in the same cycle, and changed=1 in that cycle.
- Post-reset
  - If swt_raw bits are 1 when rst deasserts, those bits are accepted after the normal latency and generate rise pulses. This is intended.
- Counter overflow
  - The counter never exceeds CNT_MAX-1, so it cannot wrap.

Test Plan:
(Bench parameters: CNT_MAX=4, SYNC_STAGES=2.)
1. Reset check: hold rst=1 for 3 cycles with swt_raw=8'hFF, then check swt=0, rise=0, fall=0, changed=0. Release rst → swt=8'hFF on the 6th edge after release, with rise=8'hFF and changed=1 for exactly that one cycle.
2. Clean step: from swt=0, set swt_raw[3]=1 and hold → swt=8'h08 at edge 6. rise[3] pulses one cycle and fall stays 0. Then clear swt_raw[3] → swt=0 six edges later with a single fall[3] pulse.
3. Glitch rejection: pulse swt_raw[0] high for 3 cycles, then low → swt[0] stays 0 and no rise/fall/changed at any time. Repeat a 1-0-1-0 bounce pattern for 20 cycles ending at 0 → no output change.
4. Bounce then settle: toggle swt_raw[5] every 2 cycles for 10 cycles, then hold at 1 → swt[5]=1 exactly 6 edges after the last toggle, with exactly one rise[5] pulse.
5. Independent bits: change swt_raw from 8'h00 to 8'hA5 in one cycle → swt=8'hA5 at edge 6, rise=8'hA5 for one cycle, changed=1 for one cycle only. Then change only bit 7 → only fall[7] pulses.
6. Reset mid-count: set swt_raw[1]=1 and assert rst at edge 4 for 1 cycle → swt stays 0 through reset. After release, swt[1]=1 at the 6th edge after release, confirming the counter restarted.
